// File: rtl/oc_issue_sched.sv
// oc_issue_sched
//   Issue scheduler downstream of the 4-entry operand collector. Each cycle it
//   picks at most one ready collector for the ALU pipe and at most one for the
//   MEM pipe using independent round-robin pointers. It drives the release
//   grants and a same-cycle select index. It also holds a one-entry issue
//   register per pipe with a valid/ready handshake toward EX. Wrapping issue
//   counters are provided for performance monitoring.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   RDY[3:0]           collector i holds all operands and is valid
//   IsMem[3:0]         collector i holds a memory op
//   ALU_Ready          ALU EX consumes the ALU issue register this cycle
//   MEM_Ready          MEM stage consumes the MEM issue register this cycle
//   Flush              kills both issue registers, suppresses grants
//   ALU/MEM_Grt_Sched_OC  one-hot-or-zero grant / release strobe
//   ALU/MEM_Sel_OCID      index of the current grant (0 when none)
//   ALU/MEM_Issue_Valid   issue register occupied
//   ALU/MEM_Issue_OCID    collector index held in the issue register
//   ALU/MEM_Issue_Cnt     wrapping grant counters
module oc_issue_sched #(
    parameter int NUM_OC = 4,
    parameter int OCID_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_OC-1:0] RDY,
    input  logic [NUM_OC-1:0] IsMem,
    input  logic              ALU_Ready,
    input  logic              MEM_Ready,
    input  logic              Flush,
    output logic [NUM_OC-1:0] ALU_Grt_Sched_OC,
    output logic [NUM_OC-1:0] MEM_Grt_Sched_OC,
    output logic [OCID_W-1:0] ALU_Sel_OCID,
    output logic [OCID_W-1:0] MEM_Sel_OCID,
    output logic              ALU_Issue_Valid,
    output logic [OCID_W-1:0] ALU_Issue_OCID,
    output logic              MEM_Issue_Valid,
    output logic [OCID_W-1:0] MEM_Issue_OCID,
    output logic [CNT_W-1:0]  ALU_Issue_Cnt,
    output logic [CNT_W-1:0]  MEM_Issue_Cnt
);

    logic [OCID_W-1:0] alu_ptr;
    logic [OCID_W-1:0] mem_ptr;

    logic [NUM_OC-1:0] elig_alu;
    logic [NUM_OC-1:0] elig_mem;
    logic              can_alu;
    logic              can_mem;

    logic              alu_found;
    logic              mem_found;
    logic [OCID_W-1:0] alu_idx;
    logic [OCID_W-1:0] mem_idx;
    logic [OCID_W-1:0] cand_alu;
    logic [OCID_W-1:0] cand_mem;
    logic              alu_fire;
    logic              mem_fire;

    assign elig_alu = RDY & ~IsMem;
    assign elig_mem = RDY & IsMem;
    assign can_alu  = ~ALU_Issue_Valid | ALU_Ready;
    assign can_mem  = ~MEM_Issue_Valid | MEM_Ready;

    // Scan ptr, ptr+1, ... (mod NUM_OC); first eligible index wins.
    always_comb begin
        alu_found = 1'b0;
        mem_found = 1'b0;
        alu_idx   = '0;
        mem_idx   = '0;
        cand_alu  = '0;
        cand_mem  = '0;
        for (int unsigned off = 0; off < NUM_OC; off++) begin
            cand_alu = alu_ptr + OCID_W'(off);
            cand_mem = mem_ptr + OCID_W'(off);
            if (!alu_found && elig_alu[cand_alu]) begin
                alu_found = 1'b1;
                alu_idx   = cand_alu;
            end
            if (!mem_found && elig_mem[cand_mem]) begin
                mem_found = 1'b1;
                mem_idx   = cand_mem;
            end
        end
    end

    // rst gates the grants: the cleared issue registers alone would
    // otherwise allow a grant while reset is still held.
    assign alu_fire = alu_found & can_alu & ~Flush & ~rst;
    assign mem_fire = mem_found & can_mem & ~Flush & ~rst;

    always_comb begin
        ALU_Grt_Sched_OC = '0;
        MEM_Grt_Sched_OC = '0;
        ALU_Sel_OCID     = '0;
        MEM_Sel_OCID     = '0;
        if (alu_fire) begin
            ALU_Grt_Sched_OC[alu_idx] = 1'b1;
            ALU_Sel_OCID              = alu_idx;
        end
        if (mem_fire) begin
            MEM_Grt_Sched_OC[mem_idx] = 1'b1;
            MEM_Sel_OCID              = mem_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ptr         <= '0;
            ALU_Issue_Valid <= 1'b0;
            ALU_Issue_OCID  <= '0;
            ALU_Issue_Cnt   <= '0;
        end else if (Flush) begin
            ALU_Issue_Valid <= 1'b0;
        end else if (alu_fire) begin
            ALU_Issue_Valid <= 1'b1;
            ALU_Issue_OCID  <= alu_idx;
            alu_ptr         <= alu_idx + OCID_W'(1);
            ALU_Issue_Cnt   <= ALU_Issue_Cnt + CNT_W'(1);
        end else if (ALU_Ready) begin
            ALU_Issue_Valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ptr         <= '0;
            MEM_Issue_Valid <= 1'b0;
            MEM_Issue_OCID  <= '0;
            MEM_Issue_Cnt   <= '0;
        end else if (Flush) begin
            MEM_Issue_Valid <= 1'b0;
        end else if (mem_fire) begin
            MEM_Issue_Valid <= 1'b1;
            MEM_Issue_OCID  <= mem_idx;
            mem_ptr         <= mem_idx + OCID_W'(1);
            MEM_Issue_Cnt   <= MEM_Issue_Cnt + CNT_W'(1);
        end else if (MEM_Ready) begin
            MEM_Issue_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_oc_issue_sched.sv
// tb_oc_issue_sched
//   Directed testbench for oc_issue_sched. Inputs change 1 ns after the rising
//   edge and outputs are sampled 1 ns later, well away from the edge.
module tb_oc_issue_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  RDY;
    logic [3:0]  IsMem;
    logic        ALU_Ready;
    logic        MEM_Ready;
    logic        Flush;
    logic [3:0]  ALU_Grt_Sched_OC;
    logic [3:0]  MEM_Grt_Sched_OC;
    logic [1:0]  ALU_Sel_OCID;
    logic [1:0]  MEM_Sel_OCID;
    logic        ALU_Issue_Valid;
    logic [1:0]  ALU_Issue_OCID;
    logic        MEM_Issue_Valid;
    logic [1:0]  MEM_Issue_OCID;
    logic [15:0] ALU_Issue_Cnt;
    logic [15:0] MEM_Issue_Cnt;

    int tests = 0;
    int fails = 0;

    oc_issue_sched #(.NUM_OC(4), .OCID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .RDY(RDY), .IsMem(IsMem),
        .ALU_Ready(ALU_Ready), .MEM_Ready(MEM_Ready), .Flush(Flush),
        .ALU_Grt_Sched_OC(ALU_Grt_Sched_OC), .MEM_Grt_Sched_OC(MEM_Grt_Sched_OC),
        .ALU_Sel_OCID(ALU_Sel_OCID), .MEM_Sel_OCID(MEM_Sel_OCID),
        .ALU_Issue_Valid(ALU_Issue_Valid), .ALU_Issue_OCID(ALU_Issue_OCID),
        .MEM_Issue_Valid(MEM_Issue_Valid), .MEM_Issue_OCID(MEM_Issue_OCID),
        .ALU_Issue_Cnt(ALU_Issue_Cnt), .MEM_Issue_Cnt(MEM_Issue_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; RDY = 4'b1111; IsMem = 4'b0101;
        ALU_Ready = 1'b1; MEM_Ready = 1'b1; Flush = 1'b0;
        step(); step(); #1;
        tests++; if (ALU_Grt_Sched_OC !== 4'b0000) begin fails++; $display("FAIL rst_alu_grt: got %b want 0000", ALU_Grt_Sched_OC); end
        tests++; if (MEM_Grt_Sched_OC !== 4'b0000) begin fails++; $display("FAIL rst_mem_grt: got %b want 0000", MEM_Grt_Sched_OC); end
        tests++; if ({ALU_Issue_Valid, MEM_Issue_Valid} !== 2'b00) begin fails++; $display("FAIL rst_valid: got %b want 00", {ALU_Issue_Valid, MEM_Issue_Valid}); end
        tests++; if ({ALU_Issue_OCID, MEM_Issue_OCID} !== 4'b0000) begin fails++; $display("FAIL rst_ocid: got %b want 0000", {ALU_Issue_OCID, MEM_Issue_OCID}); end
        tests++; if ({ALU_Issue_Cnt, MEM_Issue_Cnt} !== 32'd0) begin fails++; $display("FAIL rst_cnt: got %h want 0", {ALU_Issue_Cnt, MEM_Issue_Cnt}); end
        step();
        rst = 1'b0; RDY = 4'b0000; IsMem = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if ({ALU_Grt_Sched_OC, MEM_Grt_Sched_OC} !== 8'h00) begin fails++; $display("FAIL idle_grt[%0d]: got %b want 00000000", c, {ALU_Grt_Sched_OC, MEM_Grt_Sched_OC}); end
            tests++; if ({ALU_Issue_Valid, MEM_Issue_Valid, ALU_Issue_Cnt, MEM_Issue_Cnt} !== 34'd0) begin fails++; $display("FAIL idle_state[%0d]: got %h want 0", c, {ALU_Issue_Valid, MEM_Issue_Valid, ALU_Issue_Cnt, MEM_Issue_Cnt}); end
            step();
        end
    endtask

    // Collectors release on their grant, so RDY loses the granted bit each cycle.
    task automatic test_alu_round_robin();
        logic [3:0] rdy_seq [4];
        logic [3:0] grt_exp [4];
        rdy_seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
        grt_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        IsMem = 4'b0000; ALU_Ready = 1'b1; MEM_Ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            RDY = rdy_seq[c];
            #1;
            tests++; if (ALU_Grt_Sched_OC !== grt_exp[c]) begin fails++; $display("FAIL rr_grt[%0d]: got %b want %b", c, ALU_Grt_Sched_OC, grt_exp[c]); end
            tests++; if (ALU_Sel_OCID !== 2'(c)) begin fails++; $display("FAIL rr_sel[%0d]: got %0d want %0d", c, ALU_Sel_OCID, c); end
            tests++; if (MEM_Grt_Sched_OC !== 4'b0000) begin fails++; $display("FAIL rr_mem_grt[%0d]: got %b want 0000", c, MEM_Grt_Sched_OC); end
            step();
            tests++; if ({ALU_Issue_Valid, ALU_Issue_OCID} !== {1'b1, 2'(c)}) begin fails++; $display("FAIL rr_issue[%0d]: got v%b id%0d want v1 id%0d", c, ALU_Issue_Valid, ALU_Issue_OCID, c); end
        end
        tests++; if (ALU_Issue_Cnt !== 16'd4) begin fails++; $display("FAIL rr_cnt: got %0d want 4", ALU_Issue_Cnt); end
        RDY = 4'b0000;
        step();
        tests++; if (ALU_Issue_Valid !== 1'b0) begin fails++; $display("FAIL rr_drain: got %b want 0", ALU_Issue_Valid); end
    endtask

    task automatic test_mixed();
        RDY = 4'b1111; IsMem = 4'b1010; ALU_Ready = 1'b1; MEM_Ready = 1'b1;
        #1;
        tests++; if ({ALU_Grt_Sched_OC, MEM_Grt_Sched_OC} !== 8'b0001_0010) begin fails++; $display("FAIL mix_grt1: got %b want 00010010", {ALU_Grt_Sched_OC, MEM_Grt_Sched_OC}); end
        tests++; if ({ALU_Sel_OCID, MEM_Sel_OCID} !== 4'b00_01) begin fails++; $display("FAIL mix_sel1: got %b want 0001", {ALU_Sel_OCID, MEM_Sel_OCID}); end
        step();
        RDY = 4'b1100;
        #1;
        tests++; if ({ALU_Grt_Sched_OC, MEM_Grt_Sched_OC} !== 8'b0100_1000) begin fails++; $display("FAIL mix_grt2: got %b want 01001000", {ALU_Grt_Sched_OC, MEM_Grt_Sched_OC}); end
        step();
        tests++; if ({ALU_Issue_OCID, MEM_Issue_OCID} !== 4'b10_11) begin fails++; $display("FAIL mix_ocid: got %b want 1011", {ALU_Issue_OCID, MEM_Issue_OCID}); end
        tests++; if ({ALU_Issue_Cnt, MEM_Issue_Cnt} !== {16'd6, 16'd2}) begin fails++; $display("FAIL mix_cnt: got %0d/%0d want 6/2", ALU_Issue_Cnt, MEM_Issue_Cnt); end
        RDY = 4'b0000;
        step();
        tests++; if ({ALU_Issue_Valid, MEM_Issue_Valid} !== 2'b00) begin fails++; $display("FAIL mix_drain: got %b want 00", {ALU_Issue_Valid, MEM_Issue_Valid}); end
    endtask

    // alu_ptr is 3 on entry.
    task automatic test_stall_and_fairness();
        RDY = 4'b0001; IsMem = 4'b0000; ALU_Ready = 1'b1;
        #1;
        tests++; if (ALU_Grt_Sched_OC !== 4'b0001) begin fails++; $display("FAIL wrap_grt: got %b want 0001", ALU_Grt_Sched_OC); end
        step();
        ALU_Ready = 1'b0; RDY = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (ALU_Grt_Sched_OC !== 4'b0000) begin fails++; $display("FAIL stall_grt[%0d]: got %b want 0000", c, ALU_Grt_Sched_OC); end
            tests++; if ({ALU_Issue_Valid, ALU_Issue_OCID} !== 3'b1_00) begin fails++; $display("FAIL stall_hold[%0d]: got v%b id%0d want v1 id0", c, ALU_Issue_Valid, ALU_Issue_OCID); end
            step();
        end
        ALU_Ready = 1'b1;
        #1;
        tests++; if ({ALU_Grt_Sched_OC, ALU_Sel_OCID} !== 6'b0100_10) begin fails++; $display("FAIL unstall_grt: got %b/%0d want 0100/2", ALU_Grt_Sched_OC, ALU_Sel_OCID); end
        step();
        tests++; if ({ALU_Issue_Valid, ALU_Issue_OCID, ALU_Issue_Cnt} !== {1'b1, 2'd2, 16'd8}) begin fails++; $display("FAIL unstall_issue: got v%b id%0d cnt%0d want v1 id2 cnt8", ALU_Issue_Valid, ALU_Issue_OCID, ALU_Issue_Cnt); end
        RDY = 4'b1001;
        #1;
        tests++; if (ALU_Grt_Sched_OC !== 4'b1000) begin fails++; $display("FAIL fair_grt1: got %b want 1000", ALU_Grt_Sched_OC); end
        step();
        RDY = 4'b0001;
        #1;
        tests++; if (ALU_Grt_Sched_OC !== 4'b0001) begin fails++; $display("FAIL fair_grt2: got %b want 0001", ALU_Grt_Sched_OC); end
        step();
        tests++; if ({ALU_Issue_OCID, ALU_Issue_Cnt} !== {2'd0, 16'd10}) begin fails++; $display("FAIL fair_issue: got id%0d cnt%0d want id0 cnt10", ALU_Issue_OCID, ALU_Issue_Cnt); end
        RDY = 4'b0000;
        step();
    endtask

    // alu_ptr is 1 and mem_ptr is 0 on entry.
    task automatic test_flush();
        RDY = 4'b0010; IsMem = 4'b0010; MEM_Ready = 1'b1; ALU_Ready = 1'b1;
        #1;
        tests++; if (MEM_Grt_Sched_OC !== 4'b0010) begin fails++; $display("FAIL flush_pre_grt: got %b want 0010", MEM_Grt_Sched_OC); end
        step();
        RDY = 4'b0001; IsMem = 4'b0000; MEM_Ready = 1'b0; Flush = 1'b1;
        #1;
        tests++; if ({ALU_Grt_Sched_OC, MEM_Grt_Sched_OC, ALU_Sel_OCID, MEM_Sel_OCID} !== 12'd0) begin fails++; $display("FAIL flush_grt: got %b want 0", {ALU_Grt_Sched_OC, MEM_Grt_Sched_OC, ALU_Sel_OCID, MEM_Sel_OCID}); end
        tests++; if ({MEM_Issue_Valid, MEM_Issue_OCID} !== 3'b1_01) begin fails++; $display("FAIL flush_mem_valid: got v%b id%0d want v1 id1", MEM_Issue_Valid, MEM_Issue_OCID); end
        step();
        Flush = 1'b0;
        tests++; if ({ALU_Issue_Valid, MEM_Issue_Valid} !== 2'b00) begin fails++; $display("FAIL flush_valid: got %b want 00", {ALU_Issue_Valid, MEM_Issue_Valid}); end
        tests++; if ({ALU_Issue_Cnt, MEM_Issue_Cnt} !== {16'd10, 16'd3}) begin fails++; $display("FAIL flush_cnt: got %0d/%0d want 10/3", ALU_Issue_Cnt, MEM_Issue_Cnt); end
        #1;
        tests++; if (ALU_Grt_Sched_OC !== 4'b0001) begin fails++; $display("FAIL flush_resume: got %b want 0001", ALU_Grt_Sched_OC); end
        step();
        tests++; if ({ALU_Issue_Valid, ALU_Issue_OCID, ALU_Issue_Cnt} !== {1'b1, 2'd0, 16'd11}) begin fails++; $display("FAIL flush_resume_issue: got v%b id%0d cnt%0d want v1 id0 cnt11", ALU_Issue_Valid, ALU_Issue_OCID, ALU_Issue_Cnt); end
    endtask

    // alu_ptr is 1 on entry; reset must send the next search back to index 0.
    task automatic test_reset_mid();
        RDY = 4'b0010; IsMem = 4'b0000;
        #1;
        tests++; if (ALU_Grt_Sched_OC !== 4'b0010) begin fails++; $display("FAIL mid_pre_grt: got %b want 0010", ALU_Grt_Sched_OC); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({ALU_Grt_Sched_OC, MEM_Grt_Sched_OC} !== 8'h00) begin fails++; $display("FAIL mid_grt: got %b want 0", {ALU_Grt_Sched_OC, MEM_Grt_Sched_OC}); end
        tests++; if ({ALU_Issue_Valid, MEM_Issue_Valid, ALU_Issue_Cnt, MEM_Issue_Cnt} !== 34'd0) begin fails++; $display("FAIL mid_state: got %h want 0", {ALU_Issue_Valid, MEM_Issue_Valid, ALU_Issue_Cnt, MEM_Issue_Cnt}); end
        step();
        rst = 1'b0; RDY = 4'b1111;
        #1;
        tests++; if ({ALU_Grt_Sched_OC, ALU_Sel_OCID} !== 6'b0001_00) begin fails++; $display("FAIL mid_restart: got %b/%0d want 0001/0", ALU_Grt_Sched_OC, ALU_Sel_OCID); end
        step();
        RDY = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_alu_round_robin();
        test_mixed();
        test_stall_and_fairness();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
